elink_trig_align_ctrl: RTL

Word-alignment and lock controller for the trigger elink unroller. It monitors the 8-bit per-clock elink word stream for the frame header byte and issues bit-slip pulses to the unroller until the header recurs at a fixed frame period. Once aligned, it declares lock, emits frame-start strobes and tracks header errors. It sits between the elink deserialiser/unroller and the downstream trigger-primitive consumers.

---
 rtl/elink_trig_align_ctrl_pkg.sv | 15 +
 rtl/elink_trig_align_ctrl_if.sv | 30 +++
 rtl/elink_trig_align_ctrl_frame_counter.sv | 40 ++++
 rtl/elink_trig_align_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/elink_trig_align_ctrl_pkg.sv
// Shared definitions for the trigger elink word-alignment logic:
// the state encoding, the default header byte and the default frame length.
package elink_trig_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_HEADER    = 8'hAF;
  localparam int         DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/elink_trig_align_ctrl_if.sv
// Bundle of the word stream from the unroller and the alignment/lock status
// returned by the controller.
//
// Flow semantics: there is no valid/ready pair on this link. data_in carries
// one word on every rising clock edge and is always consumed; enable gates
// the controller as a whole. All status signals are registered and change
// only on the rising edge; bitslip and frame_start are single-cycle pulses.
interface elink_trig_align_ctrl_if;
  logic        enable;
  logic [7:0]  data_in;
  logic        bitslip;
  logic [2:0]  slip_count;
  logic        locked;
  logic        frame_start;
  logic [7:0]  word_idx;
  logic [15:0] hdr_err_cnt;
  logic [1:0]  state;

  // Source of the word stream and consumer of the status
  modport master (
    output enable, data_in,
    input  bitslip, slip_count, locked, frame_start, word_idx, hdr_err_cnt, state
  );

  // The alignment controller
  modport slave (
    input  enable, data_in,
    output bitslip, slip_count, locked, frame_start, word_idx, hdr_err_cnt, state
  );
endinterface

// File: rtl/elink_trig_align_ctrl_frame_counter.sv
// Modulo-FRAME_LEN word position counter. idx_o is the position of the word
// sampled on the previous edge; at_hdr_o flags that the word now being
// sampled sits at the header position (the next index wraps to 0).
module elink_frame_counter
  import elink_trig_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  output logic [7:0] idx_o,
  output logic       at_hdr_o
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  logic [7:0] idx_q, idx_d;

  // Clear wins; otherwise advance and wrap at the end of the frame
  always_comb begin
    idx_d = idx_q + 8'd1;
    if (clr_i || idx_q == LAST_IDX) begin
      idx_d = '0;
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o    = idx_q;
  assign at_hdr_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/elink_trig_align_ctrl.sv
// Word-alignment and lock controller for the trigger elink unroller. Hunts
// for the header byte, bit-slips the unroller when a whole frame goes by
// without one, verifies the header period before declaring lock and counts
// header errors once locked.
module elink_trig_align_ctrl
  import elink_trig_pkg::*;
#(
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter int         FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int         LOCK_GOOD  = 4,
  parameter int         UNLOCK_BAD = 3,
  parameter int         SLIP_WAIT  = 4
) (
  input logic               clk,
  input logic               rst,
  elink_trig_align_ctrl_if.slave bus
);

  localparam logic [7:0] MISS_LAST = 8'(FRAME_LEN - 1);
  localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);
  localparam logic [3:0] GOOD_LAST = 4'(LOCK_GOOD - 1);
  localparam logic [3:0] BAD_LAST  = 4'(UNLOCK_BAD - 1);

  state_e      state_q, state_d;
  logic [7:0]  miss_q, miss_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic        bitslip_q, bitslip_d;
  logic [2:0]  slip_cnt_q, slip_cnt_d;
  logic        locked_q;
  logic        fs_q, fs_d;
  logic [15:0] hdr_err_cnt_q, hdr_err_cnt_d;

  logic        hit;
  logic        at_hdr;
  logic        fc_clr;
  logic [7:0]  word_idx;

  assign hit = (bus.data_in == HEADER);

  // The frame position only runs while staying in VERIFY/LOCKED; entering
  // VERIFY from SEARCH, or leaving either state, restarts it at the header.
  assign fc_clr = !((state_q == ST_VERIFY || state_q == ST_LOCKED) &&
                    (state_d == ST_VERIFY || state_d == ST_LOCKED));

  elink_frame_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_counter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (fc_clr),
    .idx_o    (word_idx),
    .at_hdr_o (at_hdr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision; a low enable forces SEARCH ahead of any transition
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_SEARCH;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (hit) begin
            state_d = (LOCK_GOOD == 1) ? ST_LOCKED : ST_VERIFY;
          end else if (miss_q == MISS_LAST) begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (wait_q == WAIT_LAST) state_d = ST_SEARCH;
        end
        ST_VERIFY: begin
          if (at_hdr) begin
            if (!hit)                    state_d = ST_SEARCH;
            else if (good_q == GOOD_LAST) state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (at_hdr && !hit && bad_q == BAD_LAST) state_d = ST_SEARCH;
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Counter updates and next values of the registered pulses/status
  always_comb begin
    miss_d        = '0;
    wait_d        = '0;
    good_d        = '0;
    bad_d         = '0;
    bitslip_d     = 1'b0;
    fs_d          = 1'b0;
    slip_cnt_d    = slip_cnt_q;
    hdr_err_cnt_d = hdr_err_cnt_q;
    if (bus.enable) begin
      case (state_q)
        ST_SEARCH: begin
          if (hit) begin
            good_d = 4'd1;
          end else if (miss_q == MISS_LAST) begin
            bitslip_d  = 1'b1;
            slip_cnt_d = slip_cnt_q + 3'd1;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
        ST_SLIP: begin
          if (wait_q != WAIT_LAST) wait_d = wait_q + 4'd1;
        end
        ST_VERIFY: begin
          good_d = good_q;
          if (at_hdr && hit && good_q != GOOD_LAST) good_d = good_q + 4'd1;
        end
        ST_LOCKED: begin
          bad_d = bad_q;
          if (at_hdr) begin
            if (hit) begin
              bad_d = '0;
              fs_d  = 1'b1;
            end else begin
              bad_d = (bad_q == BAD_LAST) ? 4'd0 : bad_q + 4'd1;
              if (hdr_err_cnt_q != 16'hFFFF) hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_q        <= '0;
      wait_q        <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      bitslip_q     <= 1'b0;
      slip_cnt_q    <= '0;
      locked_q      <= 1'b0;
      fs_q          <= 1'b0;
      hdr_err_cnt_q <= '0;
    end else begin
      miss_q        <= miss_d;
      wait_q        <= wait_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      bitslip_q     <= bitslip_d;
      slip_cnt_q    <= slip_cnt_d;
      locked_q      <= (state_d == ST_LOCKED);
      fs_q          <= fs_d;
      hdr_err_cnt_q <= hdr_err_cnt_d;
    end
  end

  assign bus.bitslip     = bitslip_q;
  assign bus.slip_count  = slip_cnt_q;
  assign bus.locked      = locked_q;
  assign bus.frame_start = fs_q;
  assign bus.word_idx    = word_idx;
  assign bus.hdr_err_cnt = hdr_err_cnt_q;
  assign bus.state       = state_q;

endmodule
